// File: rtl/prng_pkg.sv
// Shared types and widths for the mask-randomness path around simple_prng.
package prng_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_GEN      = 2'd1,
        ST_RESEED   = 2'd2
    } rnd_state_e;

    localparam int SEED_W         = 128;
    localparam int RND_W          = 64;
    localparam int STEPS_PER_WORD = 64;

endpackage

// File: rtl/rnd_fifo.sv
// Circular buffer of random words with a registered head word.
module rnd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  head;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_en = push && (count != DEPTH_C);
    assign rd_en = pop && (count != '0);
    assign valid = (count != '0);
    assign dout  = head;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head reloads from the incoming word whenever the buffer is (or is about to be) empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && ((count == '0) || (rd_en && (count == ONE_C)))) begin
                head <= din;
            end else if (rd_en) begin
                head <= mem[ptr_inc(rd_ptr)];
            end
        end
    end

endmodule

// File: rtl/rnd_dispenser.sv
// Seeds and steps simple_prng, keeps one word per 64 LFSR steps, and asks for reseed.
// state       | meaning
// ST_UNSEEDED | after reset, waiting for a nonzero seed
// ST_GEN      | stepping the generator, pushing every 64th step
// ST_RESEED   | word budget used up, generator halted until new seed
module rnd_dispenser
    import prng_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int RESEED_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid_i,
    input  logic [SEED_W-1:0] seed_i,
    output logic              seed_ready_o,
    output logic              seed_err_o,
    output logic              reseed_req_o,
    output logic              prng_init_o,
    output logic              prng_en_o,
    output logic [SEED_W-1:0] prng_seed_o,
    input  logic [RND_W-1:0]  prng_i,
    output logic              rnd_valid_o,
    input  logic              rnd_ready_i,
    output logic [RND_W-1:0]  rnd_o
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int WCW = (RESEED_WORDS > 1) ? $clog2(RESEED_WORDS + 1) : 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam logic [WCW-1:0] RESEED_C  = WCW'(RESEED_WORDS);
    localparam logic [5:0]     LAST_STEP = 6'(STEPS_PER_WORD - 1);

    rnd_state_e     state;
    logic [5:0]     step;
    logic [WCW-1:0] word_cnt;
    logic [WCW-1:0] word_next;
    logic [CW-1:0]  fifo_count;
    logic           seed_fire;
    logic           seed_nonzero;
    logic           push;
    logic           pop;
    logic           reseed_hit;

    assign seed_ready_o = (state == ST_UNSEEDED) || (state == ST_RESEED);
    assign seed_fire    = seed_valid_i && seed_ready_o;
    assign seed_nonzero = |seed_i;
    assign prng_init_o  = seed_fire && seed_nonzero;
    assign prng_seed_o  = seed_i;
    assign reseed_req_o = (state == ST_RESEED);

    // Stall the generator rather than drop words when the consumer is slow.
    assign prng_en_o = (state == ST_GEN) && (fifo_count < DEPTH_C);
    assign push      = prng_en_o && (step == LAST_STEP);
    assign pop       = rnd_valid_o && rnd_ready_i;

    assign word_next  = word_cnt + 1'b1;
    assign reseed_hit = (RESEED_WORDS != 0) && (word_next == RESEED_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_UNSEEDED;
            step       <= '0;
            word_cnt   <= '0;
            seed_err_o <= 1'b0;
        end else begin
            seed_err_o <= seed_fire && !seed_nonzero;
            if (prng_init_o) begin
                state    <= ST_GEN;
                step     <= '0;
                word_cnt <= '0;
            end else if (prng_en_o) begin
                step <= step + 1'b1;
                if (push) begin
                    word_cnt <= word_next;
                    if (reseed_hit) begin
                        state <= ST_RESEED;
                    end
                end
            end
        end
    end

    rnd_fifo #(
        .DEPTH (DEPTH),
        .W     (RND_W),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (prng_i),
        .pop   (pop),
        .dout  (rnd_o),
        .valid (rnd_valid_o),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_rnd_dispenser.sv
// Directed bench for rnd_dispenser with a stand-in 128-bit LFSR in place of simple_prng.
module tb_rnd_dispenser;

    localparam int DEPTH        = 4;
    localparam int RESEED_WORDS = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_valid;
    logic [127:0] seed;
    logic         seed_ready;
    logic         seed_err;
    logic         reseed_req;
    logic         prng_init;
    logic         prng_en;
    logic [127:0] prng_seed;
    logic [63:0]  prng_data;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [63:0]  rnd;

    logic [127:0] lfsr = '0;
    logic [127:0] s_main;
    logic [127:0] s_two;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rnd_dispenser #(
        .DEPTH        (DEPTH),
        .RESEED_WORDS (RESEED_WORDS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seed_valid_i (seed_valid),
        .seed_i       (seed),
        .seed_ready_o (seed_ready),
        .seed_err_o   (seed_err),
        .reseed_req_o (reseed_req),
        .prng_init_o  (prng_init),
        .prng_en_o    (prng_en),
        .prng_seed_o  (prng_seed),
        .prng_i       (prng_data),
        .rnd_valid_o  (rnd_valid),
        .rnd_ready_i  (rnd_ready),
        .rnd_o        (rnd)
    );

    // x^128 + x^29 + x^27 + x^2 + 1, shifting left; output is the low half.
    function automatic logic [127:0] lfsr_next(input logic [127:0] s);
        return {s[126:0], s[127] ^ s[28] ^ s[26] ^ s[1]};
    endfunction

    function automatic logic [63:0] gold(input logic [127:0] s, input int k);
        logic [127:0] v;
        v = s;
        for (int i = 0; i < 64 * k + 63; i++) v = lfsr_next(v);
        return v[63:0];
    endfunction

    always @(posedge clk) begin
        if (prng_init)    lfsr <= prng_seed;
        else if (prng_en) lfsr <= lfsr_next(lfsr);
    end
    assign prng_data = lfsr[63:0];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        seed_valid = 1'b0;
        seed       = '0;
        rnd_ready  = 1'b0;
        s_main     = 128'h0123456789ABCDEF0123456789ABCDEF;
        s_two      = 128'hDEADBEEF00C0FFEE5A5A5A5A12345678;

        #2;
        check("rst_seed_ready", seed_ready, 1);
        check("rst_valid", rnd_valid, 0);
        check("rst_en", prng_en, 0);
        check("rst_init", prng_init, 0);
        check("rst_reseed", reseed_req, 0);
        check("rst_err", seed_err, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // all-zero seed is refused
        seed_valid = 1'b1; seed = '0; #1;
        check("zero_init", prng_init, 0);
        check("zero_ready", seed_ready, 1);
        tick(); seed_valid = 1'b0; #1;
        check("zero_err_pulse", seed_err, 1);
        check("zero_still_unseeded", seed_ready, 1);
        check("zero_no_en", prng_en, 0);
        tick(); #1;
        check("zero_err_once", seed_err, 0);

        seed_valid = 1'b1; seed = 128'h1; #1;
        check("one_init", prng_init, 1);
        tick(); seed_valid = 1'b0; #1;
        check("one_en", prng_en, 1);
        check("one_gen_not_ready", seed_ready, 0);
        check("one_init_drop", prng_init, 0);

        rst = 1'b1; #1;
        check("async_rst_en", prng_en, 0);
        check("async_rst_ready", seed_ready, 1);
        tick(); rst = 1'b0; tick();

        // main seed accepted at cycle t
        seed_valid = 1'b1; seed = s_main; #1;
        check("main_init", prng_init, 1);
        tick(); seed_valid = 1'b0; #1;
        check("t1_en", prng_en, 1);
        check("t1_valid", rnd_valid, 0);
        repeat (63) tick(); #1;
        check("t64_valid", rnd_valid, 0);
        check("t64_en", prng_en, 1);
        tick(); #1;
        check("t65_valid", rnd_valid, 1);
        check("word0", rnd, gold(s_main, 0));

        repeat (191) tick(); #1;
        check("t256_en", prng_en, 1);
        tick(); #1;
        check("t257_full_en", prng_en, 0);
        check("full_head", rnd, gold(s_main, 0));
        repeat (10) tick(); #1;
        check("stall_en", prng_en, 0);

        // one pop reopens the generator
        rnd_ready = 1'b1; #1;
        check("pop_valid", rnd_valid, 1);
        tick(); rnd_ready = 1'b0; #1;
        check("word1", rnd, gold(s_main, 1));
        check("resume_en", prng_en, 1);
        repeat (63) tick(); #1;
        check("p64_en", prng_en, 1);
        tick(); #1;
        check("p65_full_en", prng_en, 0);
        check("p65_no_reseed", reseed_req, 0);

        rnd_ready = 1'b1;
        tick(); #1;
        check("word2", rnd, gold(s_main, 2));
        tick(); rnd_ready = 1'b0; #1;
        check("word3", rnd, gold(s_main, 3));
        check("p67_en", prng_en, 1);
        repeat (62) tick(); #1;
        check("pp_en", prng_en, 1);
        check("pp_head", rnd, gold(s_main, 3));
        check("pp_valid", rnd_valid, 1);

        // push of the last budgeted word coincides with a pop
        rnd_ready = 1'b1;
        tick(); rnd_ready = 1'b0; #1;
        check("word4", rnd, gold(s_main, 4));
        check("reseed_req", reseed_req, 1);
        check("reseed_en", prng_en, 0);
        check("reseed_ready", seed_ready, 1);
        rnd_ready = 1'b1;
        tick(); #1;
        check("word5", rnd, gold(s_main, 5));
        check("word5_valid", rnd_valid, 1);
        tick(); rnd_ready = 1'b0; #1;
        check("drained", rnd_valid, 0);
        repeat (5) tick(); #1;
        check("reseed_hold", reseed_req, 1);
        check("reseed_hold_en", prng_en, 0);

        // new seed at cycle r
        seed_valid = 1'b1; seed = s_two; #1;
        check("s2_init", prng_init, 1);
        tick(); seed_valid = 1'b0; #1;
        check("s2_reseed_clr", reseed_req, 0);
        check("s2_en", prng_en, 1);
        repeat (63) tick(); #1;
        check("r64_valid", rnd_valid, 0);
        tick(); #1;
        check("r65_valid", rnd_valid, 1);
        check("s2_word0", rnd, gold(s_two, 0));
        repeat (64) tick(); #1;
        check("r129_head", rnd, gold(s_two, 0));
        repeat (30) tick(); #1;
        check("r159_en", prng_en, 1);

        // reset at step 30 with two words queued
        rst = 1'b1; #1;
        check("mid_rst_valid", rnd_valid, 0);
        check("mid_rst_en", prng_en, 0);
        check("mid_rst_reseed", reseed_req, 0);
        check("mid_rst_init", prng_init, 0);
        check("mid_rst_ready", seed_ready, 1);
        check("mid_rst_err", seed_err, 0);
        tick(); rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(); #1;
            check("post_rst_valid", rnd_valid, 0);
            check("post_rst_en", prng_en, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
